// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with execute-stage forwarding and operand select
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [1:0]      ResultSrcD,
  input  logic            ValidD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ValidE,
  output logic [1:0]      ResultSrcE
);

  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic            alu_src_e;

  // A bubble is indistinguishable from the reset state: zeroed indices keep hazard matches off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_e       <= '0;
      rd2_e       <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ALUControlE <= '0;
      alu_src_e   <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
      ValidE      <= 1'b0;
    end else if (FlushE) begin
      rd1_e       <= '0;
      rd2_e       <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ALUControlE <= '0;
      alu_src_e   <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= '0;
      ValidE      <= 1'b0;
    end else if (!StallE) begin
      rd1_e       <= RD1D;
      rd2_e       <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      ALUControlE <= ALUControlD;
      alu_src_e   <= ALUSrcD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      BranchE     <= BranchD;
      JumpE       <= JumpD;
      ResultSrcE  <= ResultSrcD;
      ValidE      <= ValidD;
    end
  end

  // Select 11 is reserved and falls back to the registered operand.
  always_comb begin
    SrcAE = rd1_e;
    case (ForwardAE)
      2'b10:   SrcAE = ALUResultM;
      2'b01:   SrcAE = ResultW;
      default: SrcAE = rd1_e;
    endcase
  end

  always_comb begin
    WriteDataE = rd2_e;
    case (ForwardBE)
      2'b10:   WriteDataE = ALUResultM;
      2'b01:   WriteDataE = ResultW;
      default: WriteDataE = rd2_e;
    endcase
  end

  assign SrcBE = alu_src_e ? ImmExtE : WriteDataE;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage with a per-cycle reference model
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        StallE, FlushE;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ValidD;
  logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]  ResultSrcE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ResultSrcD(ResultSrcD), .ValidD(ValidD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUControlE(ALUControlE), .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ValidE(ValidE), .ResultSrcE(ResultSrcE)
  );

  // Instruction held in the E slot, as the architecture sees it.
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  aluc;
    logic        alusrc;
    logic [4:0]  ctl;
    logic [1:0]  rsrc;
  } slot_t;

  typedef struct {
    logic [31:0] srca, srcb, wd, pc, imm;
    logic [4:0]  rs1, rs2, rd, ctl;
    logic [2:0]  aluc;
    logic [1:0]  rsrc;
  } exp_t;

  slot_t bubble;
  slot_t m_e;
  exp_t  sb[$];
  logic [2:0] ops[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r, input logic [31:0] m,
                                      input logic [31:0] w);
    if (s == 2'b10) return m;
    if (s == 2'b01) return w;
    return r;
  endfunction

  function automatic slot_t d_slot();
    slot_t s;
    s.rd1 = RD1D; s.rd2 = RD2D; s.imm = ImmExtD; s.pc = PCD;
    s.rs1 = Rs1D; s.rs2 = Rs2D; s.rd = RdD; s.aluc = ALUControlD; s.alusrc = ALUSrcD;
    s.ctl = {RegWriteD, MemWriteD, BranchD, JumpD, ValidD}; s.rsrc = ResultSrcD;
    return s;
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    e.srca = fwd(ForwardAE, m_e.rd1, ALUResultM, ResultW);
    e.wd   = fwd(ForwardBE, m_e.rd2, ALUResultM, ResultW);
    e.srcb = m_e.alusrc ? m_e.imm : e.wd;
    e.pc = m_e.pc; e.imm = m_e.imm; e.rs1 = m_e.rs1; e.rs2 = m_e.rs2; e.rd = m_e.rd;
    e.ctl = m_e.ctl; e.aluc = m_e.aluc; e.rsrc = m_e.rsrc;
    return e;
  endfunction

  // Edge rule: reset wins, then flush (bubble), then stall (hold), else capture decode.
  task automatic model_edge();
    if (reset) m_e = bubble;
    else if (FlushE) m_e = bubble;
    else if (!StallE) m_e = d_slot();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    sb.push_back(make_exp());
    @(negedge clk);
    #1;
  endtask

  task automatic reset_mid();
    @(posedge clk);
    model_edge();
    #2;
    reset = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    m_e = bubble;
    sb.push_back(make_exp());
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_d();
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    ALUControlD = ops[$urandom_range(0, 4)]; ALUSrcD = 1'($urandom);
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); BranchD = 1'($urandom);
    JumpD = 1'($urandom); ResultSrcD = 2'($urandom); ValidD = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("SrcAE", SrcAE, e.srca);
      chk("SrcBE", SrcBE, e.srcb);
      chk("WriteDataE", WriteDataE, e.wd);
      chk("PCE", PCE, e.pc);
      chk("ImmExtE", ImmExtE, e.imm);
      chk("Rs1E_Rs2E_RdE", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, e.rs1, e.rs2, e.rd});
      chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, e.aluc});
      chk("ctl_RegW_MemW_Br_J_Valid", {27'd0, RegWriteE, MemWriteE, BranchE, JumpE, ValidE},
          {27'd0, e.ctl});
      chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, e.rsrc});
    end
  end

  initial begin
    bubble = '{default: '0};
    m_e = bubble;
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUResultM = '0; ResultW = '0;
    rand_d();
    repeat (2) @(negedge clk);
    #1;
    sb.push_back(make_exp());
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Pass-through with register operand B
    rand_d();
    RD1D = 32'h5; RD2D = 32'h3; ALUSrcD = 1'b0; ALUControlD = 3'b001; ValidD = 1'b1;
    tick();
    chk("pass_SrcAE", SrcAE, 32'h5);
    chk("pass_SrcBE", SrcBE, 32'h3);
    chk("pass_ALUControlE", {29'd0, ALUControlE}, 32'h1);

    // Forwarding with the stage held so only the selects change
    StallE = 1'b1; rand_d();
    ALUResultM = 32'hAAAA_0000; ResultW = 32'h0000_5555;
    ForwardAE = 2'b10;
    tick();
    chk("fwdA_M", SrcAE, 32'hAAAA_0000);
    ForwardAE = 2'b00; ForwardBE = 2'b01;
    tick();
    chk("fwdB_W_SrcBE", SrcBE, 32'h0000_5555);
    chk("fwdB_W_WriteDataE", WriteDataE, 32'h0000_5555);
    ForwardAE = 2'b11; ForwardBE = 2'b00;
    tick();
    chk("fwdA_reserved", SrcAE, 32'h5);
    StallE = 1'b0; ForwardAE = 2'b00;

    // Pass-through with immediate operand B
    RD1D = 32'h5; RD2D = 32'h3; ALUSrcD = 1'b1; ImmExtD = 32'hFFFF_FFFC; ALUControlD = 3'b001;
    tick();
    chk("imm_SrcBE", SrcBE, 32'hFFFF_FFFC);
    chk("imm_WriteDataE", WriteDataE, 32'h3);

    // Stall holds RdE for three cycles
    RdD = 5'd7; RegWriteD = 1'b1;
    tick();
    RdD = 5'd9; StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_RdE", {27'd0, RdE}, 32'd7);
    end
    StallE = 1'b0;
    tick();
    chk("release_RdE", {27'd0, RdE}, 32'd9);

    // Flush beats stall
    FlushE = 1'b1; StallE = 1'b1; RegWriteD = 1'b1; RdD = 5'd4; ValidD = 1'b1;
    tick();
    chk("flush_ctl", {27'd0, RegWriteE, 3'b000, ValidE}, 32'd0);
    chk("flush_RdE_ALUC", {24'd0, RdE, ALUControlE}, 32'd0);
    FlushE = 1'b0; StallE = 1'b0;

    // Back-to-back random instructions, no stall or flush
    for (int i = 0; i < 5; i++) begin
      rand_d();
      tick();
    end

    // Randomized stall/flush/forwarding mix, with an asynchronous reset midway
    for (int i = 0; i < 300; i++) begin
      rand_d();
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ALUResultM = $urandom; ResultW = $urandom;
      if (i == 150) begin
        reset_mid();
        chk("midreset_ValidE", {31'd0, ValidE}, 32'd0);
      end else begin
        tick();
      end
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
